// File: rtl/clkdiv_prog_if.sv
// Control and output bundle for the multi-channel programmable clock divider.
// The divider core takes the slave view; its driver takes the master view.
interface clkdiv_prog_if #(
    parameter int WIDTH = 16,
    parameter int CH    = 2
);
    logic [CH-1:0]       en;
    logic [CH-1:0]       mode;
    logic [CH-1:0]       load;
    logic [CH*WIDTH-1:0] div_in;
    logic [CH-1:0]       clkout;
    logic [CH-1:0]       tick;
    logic [CH-1:0]       pending;

    modport master (
        output en, mode, load, div_in,
        input  clkout, tick, pending
    );

    modport slave (
        input  en, mode, load, div_in,
        output clkout, tick, pending
    );
endinterface

// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock divider with square or pulse output.
// New divisors are staged and take effect only at the channel's wrap edge.
module clkdiv_prog #(
    parameter int WIDTH       = 16,
    parameter int CH          = 2,
    parameter int DEFAULT_DIV = 100
) (
    input logic          clkin,
    input logic          clrn,
    clkdiv_prog_if.slave bus
);
    typedef logic [WIDTH-1:0] word_t;

    localparam word_t DEF_D = word_t'(DEFAULT_DIV);
    localparam word_t ONE   = word_t'(1);
    localparam word_t TWO   = word_t'(2);

    word_t         cnt_q [CH];
    word_t         div_q [CH];
    word_t         pdiv_q[CH];
    logic [CH-1:0] pend_q;
    logic [CH-1:0] clk_q;
    logic [CH-1:0] tick_q;

    word_t         cnt_d [CH];
    word_t         div_d [CH];
    word_t         ldv_d [CH];
    logic [CH-1:0] wrap_d;
    logic [CH-1:0] sq_d;

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            ldv_d[k] = bus.div_in[k*WIDTH +: WIDTH];
            if (ldv_d[k] < TWO) begin
                ldv_d[k] = TWO;
            end
            wrap_d[k] = (cnt_q[k] == (div_q[k] - ONE));
            cnt_d[k]  = wrap_d[k] ? '0 : (cnt_q[k] + ONE);
            // The staged divisor already governs the period starting here.
            div_d[k]  = (wrap_d[k] && pend_q[k]) ? pdiv_q[k] : div_q[k];
            sq_d[k]   = (cnt_d[k] < (div_d[k] >> 1));
        end
    end

    always_ff @(posedge clkin or negedge clrn) begin
        if (!clrn) begin
            for (int k = 0; k < CH; k++) begin
                cnt_q[k]  <= DEF_D - ONE;
                div_q[k]  <= DEF_D;
                pdiv_q[k] <= '0;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (bus.en[k]) begin
                    cnt_q[k]  <= cnt_d[k];
                    div_q[k]  <= div_d[k];
                    tick_q[k] <= wrap_d[k];
                    clk_q[k]  <= bus.mode[k] ? wrap_d[k] : sq_d[k];
                    if (wrap_d[k]) begin
                        pend_q[k] <= 1'b0;
                    end
                end else begin
                    tick_q[k] <= 1'b0;
                end
                // A load on the wrap edge stays pending for the next wrap.
                if (bus.load[k]) begin
                    pdiv_q[k] <= ldv_d[k];
                    pend_q[k] <= 1'b1;
                end
            end
        end
    end

    assign bus.clkout  = clk_q;
    assign bus.tick    = tick_q;
    assign bus.pending = pend_q;
endmodule

// File: tb/tb_clkdiv_prog.sv
// Self-checking bench for clkdiv_prog: cycle scoreboard plus
// period/duty vectors and hand-written corner sequences.
module tb_clkdiv_prog;
    localparam int WIDTH = 16;
    localparam int CH    = 2;
    localparam int DEF   = 100;
    localparam int OBW   = 3 * CH;

    typedef struct {
        int ch;
        bit md;
        int div;
        int hi;
        int per;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    clkdiv_prog_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

    clkdiv_prog #(
        .WIDTH      (WIDTH),
        .CH         (CH),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clkin(clk),
        .clrn (rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    int            m_cnt[CH];
    int            m_d  [CH];
    int            m_p  [CH];
    logic [CH-1:0] m_clk;
    logic [CH-1:0] m_tick;
    logic [CH-1:0] m_pend;

    logic [OBW-1:0] sb[$];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < CH; k++) begin
            m_cnt[k] = DEF - 1;
            m_d[k]   = DEF;
            m_p[k]   = 0;
        end
        m_clk  = '0;
        m_tick = '0;
        m_pend = '0;
    endtask

    // Reference behaviour of one clock edge, from the current inputs.
    task automatic m_step();
        bit w;
        int nx;
        int dn;
        int v;
        for (int k = 0; k < CH; k++) begin
            if (bus.en[k]) begin
                w  = (m_cnt[k] == m_d[k] - 1);
                nx = w ? 0 : m_cnt[k] + 1;
                dn = m_d[k];
                if (w && m_pend[k]) begin
                    dn        = m_p[k];
                    m_pend[k] = 1'b0;
                end
                m_cnt[k]  = nx;
                m_d[k]    = dn;
                m_tick[k] = w;
                m_clk[k]  = bus.mode[k] ? w : (2 * nx + 2 <= dn);
            end else begin
                m_tick[k] = 1'b0;
            end
            if (bus.load[k]) begin
                v         = int'(bus.div_in[k*WIDTH +: WIDTH]);
                m_p[k]    = (v < 2) ? 2 : v;
                m_pend[k] = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        logic [OBW-1:0] e;
        logic [OBW-1:0] a;
        m_step();
        sb.push_back({m_clk, m_tick, m_pend});
        @(posedge clk);
        #1;
        bus.load = '0;
        a = {bus.clkout, bus.tick, bus.pending};
        e = sb.pop_front();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL sb_cycle actual=%b required=%b t=%0t", a, e, $time);
        end
    endtask

    // Starts on a tick sample; returns high samples and edges to next tick.
    task automatic measure(input int k, output int hi, output int per);
        hi  = int'(bus.clkout[k]);
        per = 0;
        while (per < 2000) begin
            cyc();
            per++;
            if (bus.tick[k]) break;
            hi += int'(bus.clkout[k]);
        end
    endtask

    task automatic apply_div(input int k, input bit md, input int dv);
        int n;
        bus.mode[k] = md;
        bus.div_in[k*WIDTH +: WIDTH] = WIDTH'(dv);
        bus.load[k] = 1'b1;
        cyc();
        n = 0;
        while (bus.pending[k] && n < 400) begin
            cyc();
            n++;
        end
        chk("apply_tick", int'(bus.tick[k]), 1);
    endtask

    task automatic wait_tick(input int k);
        int n;
        n = 0;
        while (!bus.tick[k] && n < 400) begin
            cyc();
            n++;
        end
        chk("align_tick", int'(bus.tick[k]), 1);
    endtask

    vec_t vt[6];
    int   hi;
    int   per;
    int   n;
    logic hold;

    initial begin
        vt[0] = '{ch: 0, md: 1'b0, div: 0,  hi: 1, per: 2};
        vt[1] = '{ch: 0, md: 1'b0, div: 1,  hi: 1, per: 2};
        vt[2] = '{ch: 1, md: 1'b1, div: 3,  hi: 1, per: 3};
        vt[3] = '{ch: 1, md: 1'b0, div: 9,  hi: 4, per: 9};
        vt[4] = '{ch: 0, md: 1'b0, div: 6,  hi: 3, per: 6};
        vt[5] = '{ch: 1, md: 1'b0, div: 2,  hi: 1, per: 2};

        bus.en     = '0;
        bus.mode   = '0;
        bus.load   = '0;
        bus.div_in = '0;
        m_reset();
        #1 rst_n = 1'b0;
        #11;
        chk("reset_out", int'({bus.clkout, bus.tick, bus.pending}), 0);
        rst_n = 1'b1;

        // Default ratio, period-aligned start.
        bus.en = '1;
        cyc();
        chk("first_tick", int'(bus.tick[0]), 1);
        chk("first_clk", int'(bus.clkout[0]), 1);
        measure(0, hi, per);
        chk("def_hi", hi, 50);
        chk("def_per", per, 100);

        // Enable freeze at cnt=30 for 10 cycles.
        repeat (30) cyc();
        hold = bus.clkout[0];
        bus.en[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("frz_tick", int'(bus.tick[0]), 0);
            chk("frz_clk", int'(bus.clkout[0]), int'(hold));
        end
        bus.en[0] = 1'b1;
        per = 40;
        n = 0;
        while (n < 400) begin
            cyc();
            per++;
            n++;
            if (bus.tick[0]) break;
        end
        chk("frz_per", per, 110);
        measure(0, hi, per);
        chk("frz_next", per, 100);

        // Deferred odd load on ch1 at cnt=20.
        wait_tick(1);
        repeat (20) cyc();
        bus.div_in[WIDTH +: WIDTH] = WIDTH'(7);
        bus.load[1] = 1'b1;
        cyc();
        n = int'(bus.pending[1]);
        while (bus.pending[1] && n < 400) begin
            cyc();
            if (bus.pending[1]) n++;
        end
        chk("dl_pend", n, 79);
        chk("dl_tick", int'(bus.tick[1]), 1);
        measure(1, hi, per);
        chk("dl7_hi", hi, 3);
        chk("dl7_per", per, 7);
        measure(1, hi, per);
        chk("dl7_per2", per, 7);

        // Pulse mode 5, then load 9 on a wrap edge.
        apply_div(0, 1'b1, 5);
        measure(0, hi, per);
        chk("p5_hi", hi, 1);
        chk("p5_per", per, 5);
        repeat (4) cyc();
        bus.div_in[0 +: WIDTH] = WIDTH'(9);
        bus.load[0] = 1'b1;
        cyc();
        chk("col_tick", int'(bus.tick[0]), 1);
        chk("col_pend", int'(bus.pending[0]), 1);
        measure(0, hi, per);
        chk("col_per5", per, 5);
        chk("col_pend0", int'(bus.pending[0]), 0);
        measure(0, hi, per);
        chk("col_per9", per, 9);
        chk("col_hi9", hi, 1);

        // Ratio / clamp / mode vectors.
        for (int i = 0; i < 6; i++) begin
            apply_div(vt[i].ch, vt[i].md, vt[i].div);
            measure(vt[i].ch, hi, per);
            chk($sformatf("vec%0d_hi", i), hi, vt[i].hi);
            chk($sformatf("vec%0d_per", i), per, vt[i].per);
        end

        // Asynchronous reset between edges with a load pending.
        bus.div_in[WIDTH +: WIDTH] = WIDTH'(11);
        bus.load[1] = 1'b1;
        cyc();
        chk("ar_pre_pend", int'(bus.pending[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out", int'({bus.clkout, bus.tick, bus.pending}), 0);
        m_reset();
        #1 rst_n = 1'b1;
        bus.mode = '0;
        cyc();
        chk("ar_tick", int'(bus.tick[1]), 1);
        chk("ar_pend", int'(bus.pending), 0);
        measure(1, hi, per);
        chk("ar_hi", hi, 50);
        chk("ar_per", per, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clkdiv_prog.md
# clkdiv_prog

Parametrised, multi-channel programmable clock divider. It is the successor to the fixed divide-by-100 divider. Each channel divides the system clock `clkin` by a run-time-loadable ratio and offers two output modes: 50%-style square wave or single-cycle pulse. Divisor changes are applied glitch-free at the channel's period boundary. The outputs feed the display-scan, debounce and timebase logic as clock-enables or slow clocks.

## Interface
Parameters:
- `WIDTH`, 16: counter and divisor width in bits.
- `CH`, 2: number of independent channels.
- `DEFAULT_DIV`, 100: divisor after reset. Must be in the range 2 to 2^WIDTH−1.

Ports:
- `clkin` (in, 1): system clock; all state updates on its rising edge.
- `clrn` (in, 1): reset, asynchronous, active-low.
- `en` (in, CH): per-channel count enable.
- `mode` (in, CH): per-channel output mode. 0 = square, 1 = pulse.
- `load` (in, CH): per-channel divisor load strobe, one cycle.
- `div_in` (in, CH*WIDTH): packed divisors. Channel k uses bits [k*WIDTH +: WIDTH].
- `clkout` (out, CH): divided output, registered.
- `tick` (out, CH): one-cycle pulse when the channel counter wraps to 0, registered.
- `pending` (out, CH): a loaded divisor is waiting to be applied.

## Operation
Per-channel state:
- `cnt` (WIDTH bits).
- Active divisor `D` (WIDTH bits).
- Pending divisor `P` (WIDTH bits).
- `pending` flag.
- `clkout` and `tick` flops.

Reset (`clrn`=0, asynchronous, can occur at any time including mid-period):
- `cnt` = DEFAULT_DIV−1, `D` = DEFAULT_DIV, `P` = 0.
- `pending` = 0, `clkout` = 0, `tick` = 0.

Counting, on a clock edge with `en[k]`=1:
- `wrap` = (`cnt` == `D`−1).
- `cnt_next` = 0 if `wrap`, else `cnt`+1.
- If `wrap` and `pending`=1: `D` ← `P` and `pending` ← 0. The new `D` governs the period that starts at `cnt`=0.
- `tick` ← `wrap`.
- Square mode: `clkout` ← (`cnt_next` < `Dn`>>1), where `Dn` is the divisor in force after this edge. For odd `Dn`, high for floor(`Dn`/2) cycles and low for ceil(`Dn`/2).
- Pulse mode: `clkout` ← `wrap`.
- Comparisons are unsigned, WIDTH bits. No overflow is possible because `cnt` is always ≤ `D`−1.

Counting, on a clock edge with `en[k]`=0:
- `cnt`, `D` and `clkout` hold.
- `tick` ← 0.
- A pending divisor stays pending.

Load:
- On an edge with `load[k]`=1, `P` ← clamp(`div_in` slice) and `pending` ← 1.
- clamp(x) is 2 when x < 2, otherwise x.
- Load works regardless of `en[k]`.
- A load while already pending overwrites `P` (last write wins).
- Load on the same edge as `wrap`: the old `P` (if `pending`) is applied at this wrap. The new value becomes `P` with `pending`=1 and is applied at the following wrap.

Mode change:
- Takes effect on the next enabled edge.
- No reset of `cnt` is required.

Channels are fully independent and share only `clkin`/`clrn`.

## Timing
- All outputs are flop outputs. There is no combinational path from any input to `clkout`, `tick` or `pending`.
- First enabled edge after reset wraps immediately: `tick`=1, and in square mode `clkout`=1. This gives period-aligned startup.
- Output period is exactly `D` enabled edges. Disabled cycles stretch the current period one-for-one.
- `pending` rises the cycle after `load` and falls the cycle after the applying wrap edge.
- Load-to-effect latency is bounded by the remaining cycles of the current period plus the time `en` is low.

## Test plan
1. **Default ratio.** Release `clrn`, `en`=1, `mode`=0, no loads.
   - `clkout[0]` period is 100 cycles: high 50, low 50.
   - `tick[0]` is high on the first enabled edge, then every 100 cycles.
2. **Enable freeze.** Drop `en[0]` for 10 cycles at `cnt`=30.
   - `clkout` holds its value and `tick` stays 0.
   - The period containing the stall measures 110 cycles; following periods are 100.
3. **Deferred load, odd ratio.** On ch1, load `div_in`=7 at `cnt`=20.
   - `pending[1]`=1 until the wrap at cycle 100.
   - The current 100-cycle period completes unchanged.
   - After that: high 3, low 4, repeating. No runt pulses.
4. **Pulse mode and load collision.** Set `mode`=1 with `div_in`=5 loaded.
   - `clkout` is high for 1 cycle of every 5, coincident with `tick`.
   - Load 9 on the same edge as a wrap: the 5-cycle ratio continues one more period, then the period becomes 9.
5. **Clamping.** Load `div_in`=0, then 1.
   - Both behave as divisor 2: in square mode `clkout` toggles every enabled cycle, and `tick` fires every 2 cycles.
6. **Asynchronous reset mid-period.** Assert `clrn`=0 between clock edges while a load is pending.
   - `clkout`, `tick` and `pending` go to 0 immediately, without waiting for a clock edge.
   - After release the channel runs at divisor 100, and the pending value is discarded.
